// File: rtl/fuec_pkg.sv
// Shared widths, FSM state encoding, codeword layout and parity-check columns
// for the 12/8 single-error-correcting scrubber.
package fuec_pkg;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned PAR_W  = 4;
    localparam int unsigned CW_W   = 12;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        WAIT,
        CHECK,
        WRITE,
        NEXT,
        DONE
    } state_t;

    typedef struct packed {
        logic [PAR_W-1:0]  par;
        logic [DATA_W-1:0] data;
    } codeword_t;

    // Syndrome signature of each data bit; all weight >= 2 so that a parity-only
    // flip (weight-1 syndrome) never aliases onto a data position.
    function automatic logic [PAR_W-1:0] h_col(input int bit_idx);
        case (bit_idx)
            0:       return 4'b0011;
            1:       return 4'b0101;
            2:       return 4'b0110;
            3:       return 4'b0111;
            4:       return 4'b1001;
            5:       return 4'b1010;
            6:       return 4'b1011;
            7:       return 4'b1100;
            default: return 4'b0000;
        endcase
    endfunction

endpackage

// File: rtl/fuec_scrubber_if.sv
// Memory-side bus of the scrubber: request/grant handshake plus read return.
interface fuec_scrubber_if
    import fuec_pkg::*;
#(
    parameter int unsigned ADDR_W = 4
) ();

    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [CW_W-1:0]   mem_wdata;
    logic              mem_gnt;
    logic              mem_rvalid;
    logic [CW_W-1:0]   mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_gnt, mem_rvalid, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_gnt, mem_rvalid, mem_rdata
    );

endinterface

// File: rtl/fuec_decoder_interface.sv
// Combinational single-error decoder: one-hot data error position and corrected data.
module fuec_decoder_interface
    import fuec_pkg::*;
(
    input  logic [CW_W-1:0]   cw,
    output logic [DATA_W-1:0] data_c,
    output logic [DATA_W-1:0] pos_error_c
);

    codeword_t        word;
    logic [PAR_W-1:0] par_calc;
    logic [PAR_W-1:0] syndrome;

    assign word = codeword_t'(cw);

    fuec_encoder_12_8 u_enc (
        .data  (word.data),
        .par_c (par_calc)
    );

    assign syndrome = word.par ^ par_calc;

    // Only data-bit signatures are matched; parity-only errors leave this zero.
    always_comb begin
        pos_error_c = '0;
        for (int i = 0; i < int'(DATA_W); i++) begin
            pos_error_c[i] = (syndrome == h_col(i));
        end
    end

    assign data_c = word.data ^ pos_error_c;

endmodule

// File: rtl/fuec_encoder_12_8.sv
// Combinational parity generator: XOR of the check columns of every set data bit.
module fuec_encoder_12_8
    import fuec_pkg::*;
(
    input  logic [DATA_W-1:0] data,
    output logic [PAR_W-1:0]  par_c
);

    always_comb begin
        par_c = '0;
        for (int i = 0; i < int'(DATA_W); i++) begin
            if (data[i]) par_c = par_c ^ h_col(i);
        end
    end

endmodule

// File: rtl/fuec_scrubber.sv
// Memory scrubber: reads every codeword once per pass and rewrites those with a
// correctable data-bit error, tracking a saturating count and the last fix.
module fuec_scrubber
    import fuec_pkg::*;
#(
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned CNT_W  = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    fuec_scrubber_if.master      mem,
    output logic                 busy,
    output logic                 done,
    output logic [CNT_W-1:0]     corr_cnt,
    output logic [ADDR_W-1:0]    last_err_addr,
    output logic [DATA_W-1:0]    last_pos_error
);

    state_t            state;
    logic [ADDR_W-1:0] addr;
    logic [CW_W-1:0]   word_q;
    logic              req_q;
    logic              we_q;
    logic [CW_W-1:0]   wdata_q;

    logic [DATA_W-1:0] data_dec;
    logic [DATA_W-1:0] pos_error;
    logic [PAR_W-1:0]  par_enc;

    fuec_decoder_interface u_dec (
        .cw          (word_q),
        .data_c      (data_dec),
        .pos_error_c (pos_error)
    );

    fuec_encoder_12_8 u_enc (
        .data  (data_dec),
        .par_c (par_enc)
    );

    assign mem.mem_req   = req_q;
    assign mem.mem_we    = we_q;
    assign mem.mem_addr  = addr;
    assign mem.mem_wdata = wdata_q;

    // Control FSM; bus and status outputs are set on the transition into each state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            addr           <= '0;
            word_q         <= '0;
            req_q          <= 1'b0;
            we_q           <= 1'b0;
            wdata_q        <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            corr_cnt       <= '0;
            last_err_addr  <= '0;
            last_pos_error <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        addr           <= '0;
                        corr_cnt       <= '0;
                        last_err_addr  <= '0;
                        last_pos_error <= '0;
                        busy           <= 1'b1;
                        req_q          <= 1'b1;
                        we_q           <= 1'b0;
                        state          <= READ;
                    end
                end
                READ: begin
                    if (mem.mem_gnt) begin
                        req_q <= 1'b0;
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (mem.mem_rvalid) begin
                        word_q <= mem.mem_rdata;
                        state  <= CHECK;
                    end
                end
                CHECK: begin
                    if (|pos_error) begin
                        req_q   <= 1'b1;
                        we_q    <= 1'b1;
                        wdata_q <= {par_enc, data_dec};
                        state   <= WRITE;
                    end else begin
                        state <= NEXT;
                    end
                end
                WRITE: begin
                    // word_q is untouched here, so pos_error still describes this word
                    if (mem.mem_gnt) begin
                        req_q          <= 1'b0;
                        we_q           <= 1'b0;
                        last_err_addr  <= addr;
                        last_pos_error <= pos_error;
                        if (corr_cnt != '1) corr_cnt <= corr_cnt + CNT_W'(1);
                        state          <= NEXT;
                    end
                end
                NEXT: begin
                    if (&addr) begin
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        addr  <= addr + ADDR_W'(1);
                        req_q <= 1'b1;
                        state <= READ;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
